// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM with shared period counter, double-buffered duty and breathe mode
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic                wr_mode,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((1 << WIDTH) - 2);

    logic [PRE_W-1:0]    pre;
    logic [WIDTH-1:0]    cnt;
    logic                tick;
    logic                boundary;
    logic                wr_ok;

    logic [WIDTH-1:0]    sh_duty  [CHANNELS];
    logic [CHANNELS-1:0] sh_mode;
    logic [WIDTH-1:0]    act_duty [CHANNELS];
    logic [CHANNELS-1:0] dir;
    logic [WIDTH-1:0]    act_nxt  [CHANNELS];
    logic [CHANNELS-1:0] dir_nxt;

    assign tick     = (pre == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (cnt == CNT_LAST);

    // Out-of-range channel numbers only exist when CHANNELS is not a power of two.
    generate
        if (CHANNELS == (1 << CH_W)) begin : g_full
            assign wr_ok = wr_en;
        end else begin : g_part
            assign wr_ok = wr_en && (wr_ch < CH_W'(CHANNELS));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre          <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            pre          <= tick ? '0 : pre + 1'b1;
            period_start <= boundary;
            if (tick) begin
                cnt <= boundary ? '0 : cnt + 1'b1;
            end
        end
    end

    // Breathe ramps stay inside 0..ceiling; a lowered ceiling clamps and heads down.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            act_nxt[i] = act_duty[i];
            dir_nxt[i] = dir[i];
            if (!sh_mode[i]) begin
                act_nxt[i] = sh_duty[i];
                dir_nxt[i] = 1'b0;
            end else if (sh_duty[i] == '0) begin
                act_nxt[i] = '0;
                dir_nxt[i] = 1'b0;
            end else if (act_duty[i] > sh_duty[i]) begin
                act_nxt[i] = sh_duty[i];
                dir_nxt[i] = 1'b1;
            end else if (!dir[i]) begin
                if (act_duty[i] == sh_duty[i]) begin
                    dir_nxt[i] = 1'b1;
                end else begin
                    act_nxt[i] = act_duty[i] + 1'b1;
                    dir_nxt[i] = ((act_duty[i] + 1'b1) == sh_duty[i]);
                end
            end else begin
                if (act_duty[i] == '0) begin
                    act_nxt[i] = WIDTH'(1);
                    dir_nxt[i] = 1'b0;
                end else begin
                    act_nxt[i] = act_duty[i] - 1'b1;
                    dir_nxt[i] = (act_duty[i] != WIDTH'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_mode <= '0;
            dir     <= '0;
            pwm_out <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                sh_duty[i]  <= '0;
                act_duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= (cnt < act_duty[i]);
                if (boundary) begin
                    act_duty[i] <= act_nxt[i];
                    dir[i]      <= dir_nxt[i];
                end
                if (wr_ok && (wr_ch == CH_W'(i))) begin
                    sh_duty[i] <= wr_duty;
                    sh_mode[i] <= wr_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - randomized and directed self-checking bench for pwm_bank
module tb_pwm_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_duty = '0;
    logic       wr_mode = 1'b0;
    logic [2:0] pwm_a;
    logic [3:0] pwm_b;
    logic       ps_a, ps_b;

    always #5 clk = ~clk;

    pwm_bank #(.CHANNELS(3), .WIDTH(8), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .wr_mode(wr_mode), .pwm_out(pwm_a), .period_start(ps_a)
    );

    pwm_bank #(.CHANNELS(4), .WIDTH(8), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .wr_mode(wr_mode), .pwm_out(pwm_b), .period_start(ps_b)
    );

    localparam int PER = 255;
    int n_checks = 0;
    int n_err    = 0;
    int cc [2] = '{3, 4};
    int pp [2] = '{1, 4};
    int sh_d [2][4];
    int sh_m [2][4];
    int act  [2][4];
    int dr   [2][4];
    int tt [2];
    int exp_pwm [2];
    int exp_ps  [2];
    int hi_acc  [2][4];
    int last_hi [2][4];
    int len_acc [2];
    int last_len [2];
    int ps_cnt [2] = '{0, 0};
    int ch2_seq [11] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 1, 0};

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    // Model time is counted in clocks since reset release; counter position follows by division.
    task automatic model_step(input int k);
        int pre, cnt, a, s, d;
        bit bnd;
        if (rst) begin
            tt[k] = 0;
            exp_pwm[k] = 0;
            exp_ps[k] = 0;
            for (int i = 0; i < 4; i++) begin
                sh_d[k][i] = 0; sh_m[k][i] = 0; act[k][i] = 0; dr[k][i] = 0;
            end
            return;
        end
        pre = tt[k] % pp[k];
        cnt = (tt[k] / pp[k]) % PER;
        bnd = (pre == pp[k] - 1) && (cnt == PER - 1);
        exp_pwm[k] = 0;
        for (int i = 0; i < cc[k]; i++)
            if (cnt < act[k][i]) exp_pwm[k] |= (1 << i);
        exp_ps[k] = bnd;
        if (bnd) begin
            for (int i = 0; i < cc[k]; i++) begin
                a = act[k][i]; s = sh_d[k][i]; d = dr[k][i];
                if (sh_m[k][i] == 0) begin a = s; d = 0; end
                else if (s == 0) begin a = 0; d = 0; end
                else if (a > s) begin a = s; d = 1; end
                else if (d == 0) begin
                    if (a == s) d = 1;
                    else begin a = a + 1; d = (a == s) ? 1 : 0; end
                end else begin
                    if (a == 0) begin a = 1; d = 0; end
                    else begin a = a - 1; d = (a == 0) ? 0 : 1; end
                end
                act[k][i] = a; dr[k][i] = d;
            end
        end
        if (wr_en && int'(wr_ch) < cc[k]) begin
            sh_d[k][wr_ch] = int'(wr_duty);
            sh_m[k][wr_ch] = int'(wr_mode);
        end
        tt[k]++;
    endtask

    task automatic stats(input int k, input logic p, input logic [3:0] v);
        if (p) begin
            for (int i = 0; i < 4; i++) begin
                last_hi[k][i] = hi_acc[k][i];
                hi_acc[k][i] = 0;
            end
            last_len[k] = len_acc[k];
            len_acc[k] = 0;
            ps_cnt[k]++;
        end
        len_acc[k]++;
        for (int i = 0; i < 4; i++) hi_acc[k][i] += int'(v[i]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check("pwm_a", int'(pwm_a), exp_pwm[0]);
        check("ps_a", int'(ps_a), exp_ps[0]);
        check("pwm_b", int'(pwm_b), exp_pwm[1]);
        check("ps_b", int'(ps_b), exp_ps[1]);
        stats(0, ps_a, {1'b0, pwm_a});
        stats(1, ps_b, pwm_b);
        wr_en = 1'b0;
    endtask

    task automatic arm(input int ch, input int duty, input int mode);
        wr_en = 1'b1;
        wr_ch = 2'(ch);
        wr_duty = 8'(duty);
        wr_mode = mode[0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_ps(input int k);
        int start, n;
        start = ps_cnt[k];
        n = 0;
        while (ps_cnt[k] == start && n < 3000) begin
            cycle();
            n++;
        end
        if (ps_cnt[k] == start) check("ps_timeout", ps_cnt[k] - start, 1);
    endtask

    initial begin
        int sum;
        for (int k = 0; k < 2; k++) begin
            len_acc[k] = 0; last_len[k] = 0;
            for (int i = 0; i < 4; i++) begin hi_acc[k][i] = 0; last_hi[k][i] = 0; end
        end
        idle(2);
        rst = 1'b0;

        arm(0, 64, 0); cycle();
        arm(1, 100, 0); cycle();
        arm(2, 3, 1); cycle();

        for (int n = 1; n <= 12; n++) begin
            wait_ps(0);
            if (n >= 2) check($sformatf("breathe_w%0d", n - 1), last_hi[0][2], ch2_seq[n - 2]);
            if (n == 2) begin
                check("static_hi", last_hi[0][0], 64);
                check("period_len", last_len[0], 255);
                check("ch1_w1", last_hi[0][1], 100);
                idle(50);
                arm(1, 20, 0);
            end
            if (n == 3) check("dbuf_cur", last_hi[0][1], 100);
            if (n == 4) check("dbuf_next", last_hi[0][1], 20);
            if (n == 5) begin
                idle(254);
                arm(0, 200, 0);
            end
            if (n == 6) check("bwr_w5", last_hi[0][0], 64);
            if (n == 7) check("bwr_w6", last_hi[0][0], 64);
            if (n == 8) check("bwr_w7", last_hi[0][0], 200);
            if (n == 9) arm(2, 1, 1);
        end

        arm(1, 0, 0); cycle();
        arm(2, 255, 0); cycle();
        repeat (3) wait_ps(0);
        check("duty0", last_hi[0][1], 0);
        check("duty_full", last_hi[0][2], 255);
        check("len_full", last_len[0], 255);

        arm(3, 10, 0); cycle();
        repeat (2) wait_ps(0);
        check("inv_ch0", last_hi[0][0], 200);
        check("inv_ch1", last_hi[0][1], 0);
        check("inv_ch2", last_hi[0][2], 255);
        repeat (2) wait_ps(1);
        check("pre4_hi", last_hi[1][3], 40);
        check("pre4_len", last_len[1], 1020);

        check("pre_rst_high", int'(pwm_a[2]), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_pwm_a", int'(pwm_a), 0);
        check("rst_pwm_b", int'(pwm_b), 0);
        check("rst_ps_a", int'(ps_a), 0);
        idle(2);
        rst = 1'b0;
        sum = 0;
        for (int i = 0; i < 600; i++) begin
            cycle();
            sum += int'(pwm_a != 0) + int'(pwm_b != 0);
        end
        check("idle_after_rst", sum, 0);

        for (int i = 0; i < 6000; i++) begin
            if (i == 3000) begin
                #2 rst = 1'b1;
                #1 check("rst_mid_a", int'(pwm_a), 0);
                cycle();
                rst = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: arm($urandom_range(0, 3), 0, $urandom_range(0, 1));
                    1: arm($urandom_range(0, 3), 255, $urandom_range(0, 1));
                    2: arm($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 1));
                    default: arm($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 1));
                endcase
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Multi-channel PWM generator replacing the single-channel fixed-duty `pwm` driver on the LED path. It drives `CHANNELS` independent outputs from one shared period counter, with parametrised resolution and clock prescaler. Duty values are written per channel through a simple write port and are double-buffered so that updates only take effect at period boundaries. Each channel runs in static or breathe (triangular fade) mode. The block sits between the switch/control logic and the LED output registers.

## Interface
- `CHANNELS`, 4, number of PWM outputs (≥1)
- `WIDTH`, 8, counter/duty resolution in bits (2..16); period = 2^WIDTH−1 ticks
- `PRESCALE`, 1, clock cycles per counter tick (≥1)
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  write strobe, one write per cycle
- `wr_ch`  in  CH_W = max(1, clog2(CHANNELS))  target channel
- `wr_duty`  in  WIDTH  static duty, or breathe ceiling
- `wr_mode`  in  1  0 = static, 1 = breathe
- `pwm_out`  out  CHANNELS  registered PWM outputs
- `period_start`  out  1  one-cycle pulse at the start of each period

## Operation
- Prescaler `pre` counts 0..PRESCALE−1; `tick` = (pre == PRESCALE−1). With PRESCALE=1, tick every cycle.
- Period counter `cnt` advances on tick over 0..2^WIDTH−2, then wraps to 0. `boundary` = tick && cnt == 2^WIDTH−2.
- Per-channel registers: shadow `sh_duty`/`sh_mode` (written by port); `act_duty` (compared); `dir` (breathe direction, 0 = up).
- Write: wr_en && wr_ch < CHANNELS → sh_duty[wr_ch] ← wr_duty, sh_mode[wr_ch] ← wr_mode. wr_ch ≥ CHANNELS: write ignored, no state changes.
- At boundary, per channel:
  - static: act_duty ← sh_duty; dir ← 0.
  - breathe, dir=0: if act_duty ≥ sh_duty then act_duty ← sh_duty, dir ← 1 (clamp and turn); else act_duty+1, and dir ← 1 if the new value equals sh_duty.
  - breathe, dir=1: if act_duty == 0 then act_duty ← 1 (if sh_duty>0), dir ← 0; else act_duty−1, and dir ← 0 if the new value equals 0.
  - breathe with sh_duty = 0: act_duty ← 0, dir ← 0.
  - Static→breathe switch: ramp starts from current act_duty, upward.
- Output compare: pwm_out[i] ← (cnt < act_duty[i]). Duty 0 = constantly low; duty 2^WIDTH−1 = constantly high.
- Arithmetic is unsigned, WIDTH bits; the ramp never wraps (bounded 0..sh_duty).

## Timing
- Reset (asynchronous): pre=0, cnt=0, sh_duty=0, sh_mode=0, act_duty=0, dir=0, pwm_out=0, period_start=0. The first period starts on the first tick after rst deasserts.
- Write latency: shadow updates on the edge that samples wr_en. Takes effect at the next boundary strictly after that edge. A write on the boundary edge itself is applied at the following boundary.
- act_duty updates on the boundary edge. cnt=0 and the new act_duty are visible together in the following cycle.
- pwm_out is registered: it reflects cnt/act_duty from the previous cycle (1-cycle latency).
- period_start=1 for exactly one cycle, the cycle after each boundary edge (coincident with cnt==0 being visible), every period.
- Period length = (2^WIDTH−1)·PRESCALE clocks. High time = act_duty·PRESCALE clocks.
- Reset mid-period: all state clears immediately, pwm_out drops to 0 without waiting for a clock edge.

## Test plan
- Reset: assert rst mid-run with outputs high → pwm_out=0 and period_start=0 immediately. After release, nothing goes high until a write and a boundary.
- Static: WIDTH=8, PRESCALE=1, write ch0 duty=64 → from the second period on, 64 high / 191 low clocks per 255-clock period; period_start every 255 clocks.
- Extremes and prescale: duty 0 → ch constant 0; duty 255 → constant 1 across boundaries; PRESCALE=4, duty 10 → 40 high / 1020 total clocks.
- Double-buffer: ch1 at duty 100, write 20 at cnt=50 → current period still 100 high; next period 20. A write on the boundary cycle is applied one period later.
- Breathe: ch2 mode=1, ceiling 3 → act_duty per period 1,2,3,2,1,0,1,…. Lowering the ceiling to 1 while act=3 → next period act=1, then descends.
- Invalid channel: CHANNELS=3, write wr_ch=3 → no output or shadow change on any channel.
